// File: rtl/seven_seg_scan_pkg.sv
// Shared constants for the seven-segment scanner: segment codes {g,f,e,d,c,b,a},
// segment bit positions and an index-width helper.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Never returns 0 so a single-entry counter still gets a 1-bit register.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Panel bus between the timer/controller (master) and the scanner (slave).
// The blink input exists only when SEVEN_SEG_BLINK_EN is defined.
interface seven_seg_scan_if #(parameter int DIGITS = 4);
  logic                  load;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
`ifdef SEVEN_SEG_BLINK_EN
  logic                  blink;
`endif
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
`ifdef SEVEN_SEG_BLINK_EN
    output blink,
`endif
    output load, bcd_in, dp_in, blank_lz,
    input  seg, dp, an, frame_done
  );

  modport slave (
`ifdef SEVEN_SEG_BLINK_EN
    input  blink,
`endif
    input  load, bcd_in, dp_in, blank_lz,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_seg_decode.sv
// Combinational BCD to seven-segment decoder, logical active-high; codes 10-15 blank.
module seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver with double-buffered load, leading-zero
// blanking and frame strobe. Optional blink feature: SEVEN_SEG_BLINK_EN.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b1
`ifdef SEVEN_SEG_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
)(
  input  logic            clk,
  input  logic            rst_n,
  seven_seg_scan_if.slave bus
);
  localparam int IW = clog2(DIGITS);
  localparam int DW = clog2(SCAN_DIV);

  logic [DW-1:0]            r_div;
  logic [IW-1:0]            r_idx;
  logic [DIGITS-1:0][3:0]   r_disp_bcd, r_pend_bcd;
  logic [DIGITS-1:0]        r_disp_dp, r_pend_dp;
  logic                     r_pend_vld;
  logic                     r_wrap_d;
  logic [6:0]               r_seg;
  logic                     r_dp;
  logic [DIGITS-1:0]        r_an;
  logic                     r_fd;

  logic                     w_tc, w_wrap, w_commit, w_vis;
  logic [DIGITS-1:0]        w_blank;
  logic [3:0]               w_sel_bcd;
  logic [6:0]               w_dec, w_seg_log;
  logic                     w_dp_log;
  logic [DIGITS-1:0]        w_an_log;

  assign w_tc     = (r_div == DW'(SCAN_DIV-1));
  assign w_wrap   = w_tc && (r_idx == IW'(DIGITS-1));
  // A load landing on the wrap edge is committed straight through.
  assign w_commit = w_wrap && (r_pend_vld || bus.load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_idx      <= '0;
      r_disp_bcd <= '0;
      r_disp_dp  <= '0;
      r_pend_bcd <= '0;
      r_pend_dp  <= '0;
      r_pend_vld <= 1'b0;
      r_wrap_d   <= 1'b0;
    end else begin
      r_div    <= w_tc ? '0 : r_div + 1'b1;
      r_wrap_d <= w_wrap;
      if (w_tc) r_idx <= (r_idx == IW'(DIGITS-1)) ? '0 : r_idx + 1'b1;
      if (bus.load) begin
        r_pend_bcd <= bus.bcd_in;
        r_pend_dp  <= bus.dp_in;
      end
      if (w_commit) begin
        r_disp_bcd <= bus.load ? bus.bcd_in : r_pend_bcd;
        r_disp_dp  <= bus.load ? bus.dp_in  : r_pend_dp;
        r_pend_vld <= 1'b0;
      end else if (bus.load) begin
        r_pend_vld <= 1'b1;
      end
    end
  end

  // Blank from the top digit down while digits stay zero; digit 0 always shows.
  always_comb begin
    logic run;
    w_blank = '0;
    run     = bus.blank_lz;
    for (int i = DIGITS-1; i >= 1; i--) begin
      run        = run && (r_disp_bcd[i] == 4'd0);
      w_blank[i] = run;
    end
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int FW = clog2(BLINK_FRAMES);
  logic [FW-1:0] r_fcnt;
  logic          r_phase_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt      <= '0;
      r_phase_off <= 1'b0;
    end else if (!bus.blink) begin
      r_fcnt      <= '0;
      r_phase_off <= 1'b0;
    end else if (w_wrap) begin
      if (r_fcnt == FW'(BLINK_FRAMES-1)) begin
        r_fcnt      <= '0;
        r_phase_off <= ~r_phase_off;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_vis = !(bus.blink && r_phase_off);
`else
  assign w_vis = 1'b1;
`endif

  assign w_sel_bcd = r_disp_bcd[r_idx];

  seg_decode u_dec (
    .i_bcd (w_sel_bcd),
    .o_seg (w_dec)
  );

  assign w_seg_log = w_blank[r_idx] ? SEG_BLANK : w_dec;
  assign w_dp_log  = r_disp_dp[r_idx] && !w_blank[r_idx];
  assign w_an_log  = (!w_blank[r_idx] && w_vis) ? (DIGITS'(1) << r_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= {7{SEG_ACTIVE_LOW}};
      r_dp  <= SEG_ACTIVE_LOW;
      r_an  <= {DIGITS{AN_ACTIVE_LOW}};
      r_fd  <= 1'b0;
    end else begin
      r_seg <= w_seg_log ^ {7{SEG_ACTIVE_LOW}};
      r_dp  <= w_dp_log ^ SEG_ACTIVE_LOW;
      r_an  <= w_an_log ^ {DIGITS{AN_ACTIVE_LOW}};
      r_fd  <= r_wrap_d;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.an         = r_an;
  assign bus.frame_done = r_fd;

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed seven-segment display driver for the microwave front panel. It accepts a packed multi-digit BCD value with per-digit decimal points and scans one digit at a time onto a shared segment bus with per-digit enables. It adds double-buffered loading, leading-zero blanking, selectable output polarity and a frame-done strobe. It sits between the timer/controller logic and the panel pins.

## Interface
- `DIGITS`, 4: number of digits scanned; legal 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot; legal ≥2.
- `SEG_ACTIVE_LOW`, 0: 1 inverts `seg` and `dp` at the pins.
- `AN_ACTIVE_LOW`, 1: 1 means a digit enable is asserted by driving 0.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: capture `bcd_in`/`dp_in` into the pending buffer.
- `bcd_in` in 4*DIGITS: digit i is `bcd_in[4i+3:4i]`; digit 0 is least significant.
- `dp_in` in DIGITS: decimal point per digit.
- `blank_lz` in 1: enable leading-zero blanking.
- `seg` out 7: segments {g,f,e,d,c,b,a}, registered.
- `dp` out 1: decimal point of the active digit, registered.
- `an` out DIGITS: one-hot digit enable, registered.
- `frame_done` out 1: one-cycle pulse at each frame wrap.

## Operation
- Prescaler `div_cnt` counts 0..SCAN_DIV-1. At terminal count, digit index `idx` advances modulo DIGITS.
- Double buffer:
  - `load` writes the pending register and sets `pend_valid`.
  - At the terminal count where `idx` wraps DIGITS-1→0, if `pend_valid` is set, pending copies to the display register and `pend_valid` clears.
  - Several loads within one frame: the last one wins.
  - `load` in the same cycle as the commit: the new data is committed and `pend_valid` stays clear.
- Decode (logical, active-high): 0→0111111, 1→0000110, 2→1011011, 3→1001111, 4→1100110, 5→1101101, 6→1111101, 7→0000111, 8→1111111, 9→1101111. Codes 10–15 → 0000000.
- Leading-zero blanking: with `blank_lz`=1, digits from DIGITS-1 downward that hold 0, up to the first nonzero digit, are blanked. A blanked digit has segments off, `dp` off and its `an` deasserted. Digit 0 is never blanked. `dp_in` of a blanked digit is suppressed.
- Polarity parameters apply only at the output registers.

## Timing
- Reset values:
  - `div_cnt`=0, `idx`=0.
  - Display register, pending register and `pend_valid` all 0.
  - `an` all inactive; `seg` and `dp` inactive (logical 0, inverted per parameters).
  - `frame_done`=0.
- The first digit slot begins on the first clock after reset release. `an`/`seg`/`dp` reflect digit 0 from that clock edge onward, with one-cycle output latency.
- Outputs change exactly one clock after the terminal count that changes `idx`.
- Each digit is enabled for SCAN_DIV cycles. A frame is DIGITS*SCAN_DIV cycles.
- `frame_done` is high in the cycle after the wrap terminal count, coincident with the first output cycle showing committed data.
- `blank_lz` is sampled combinationally each cycle and takes effect on the next output register update.
- Reset asserted mid-scan forces all outputs to reset values immediately (asynchronously). Pending data is lost.

## Configuration
- `SEVEN_SEG_BLINK_EN` defined:
  - Adds input `blink` (1 bit) and parameter `BLINK_FRAMES` (default 64).
  - A frame counter toggles a visibility phase every BLINK_FRAMES frames.
  - While `blink`=1 and the phase is off, all `an` are inactive. Scanning and `frame_done` continue.
  - Phase resets to visible when `blink` falls.
- `SEVEN_SEG_BLINK_EN` undefined: no `blink` port and no frame counter; the display is always visible.

## Structure
- Shared package `seven_seg_pkg`:
  - Segment code constants (SEG_0..SEG_9, SEG_BLANK).
  - Bit-position constants for a..g.
  - Index width function clog2(DIGITS).
- Sub-module `seg_decode`: combinational 4-bit→7-bit decoder per the table above. Instantiate once, on the selected digit.

## Test plan
Settings unless stated: DIGITS=4, SCAN_DIV=4, polarity defaults.
1. Reset: assert `rst_n`=0 → `an`=4'b1111, `seg`=7'b0000000, `dp`=0, `frame_done`=0. Release → `an`=4'b1110 on the next edge.
2. Load mid-frame: load 16'h1234 during the digit-2 slot while 0 is displayed → zeros continue to frame end. Then `frame_done` pulses with `an`=1110 and `seg`=1100110. Following slots show 3→1001111, 2→1011011, 1→0000110.
3. Blanking: `blank_lz`=1 with 16'h0005 → slots 3..1 have `an`=1111; slot 0 shows `seg`=1101101. With 16'h0000 → slot 0 shows 0111111.
4. Invalid code and decimal point: digit 1 = 4'hC with `dp_in`=4'b0010 → slot 1 has `seg`=0000000, `dp`=1, `an`=1101.
5. Double load and coincident commit: two loads in one frame (16'h1111 then 16'h2222) → only 2222 is displayed. Load coincident with the wrap terminal count → new data is committed and `pend_valid`=0.
6. Blink (`SEVEN_SEG_BLINK_EN`, `BLINK_FRAMES`=2): `blink`=1 → `an` alternates visible/all-1111 every 2 frames while `frame_done` keeps pulsing every 16 cycles.
